apb4_pwm_ext: RTL

APB4_PWM_EXT -- requirements
Module: apb4_pwm_ext

---
 rtl/apb4_pwm_ext.sv | 117 +++++++++++
 1 files changed

// File: rtl/apb4_pwm_ext.sv
// apb4_pwm_ext: APB4-programmable multi-channel PWM with edge/center alignment and shadowed compares
module apb4_pwm_ext #(
  parameter int CH_NUM = 4,
  parameter int CNT_WIDTH = 16,
  parameter int PSCR_WIDTH = 20
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [31:0]       paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [CH_NUM-1:0] pwm_o,
  output logic              irq_o
);
  localparam logic [5:0] CR_END = 6'(16 + CH_NUM);
  logic [5:0] off;
  logic strobe, valid, err, wr, rd, tick, pe, load;
  logic ovie, en, clr_q, mode, dn, dn_n, ovif;
  logic [PSCR_WIDTH-1:0] pscr, pscnt;
  logic [CNT_WIDTH-1:0] cnt, cnt_n, cmp_s, cmp_a, cr_rd;
  logic [CNT_WIDTH-1:0] cr_s [CH_NUM];
  logic [CNT_WIDTH-1:0] cr_a [CH_NUM];
  logic [CH_NUM-1:0] pol, raw;
  logic [31:0] rd_val;
  logic unused;

  assign off = paddr[7:2];
  assign strobe = psel & penable;
  assign valid = (off <= 6'd5) | (off >= 6'd16 & off < CR_END);
  assign err = strobe & (~valid | (pwrite & off == 6'd2));
  assign wr = strobe & pwrite & ~err;
  assign rd = strobe & ~pwrite & ~err;
  assign pready = 1'b1;
  assign pslverr = err;
  assign irq_o = ovif;
  assign tick = en & (pscnt == pscr);
  assign load = clr_q | ~en | pe;
  assign unused = ^{paddr[31:8], paddr[1:0], pwdata};

  // Counter step: CLR wins over a tick; a zero period parks the counter at 0
  always_comb begin
    cnt_n = cnt;
    dn_n = dn;
    pe = 1'b0;
    if (clr_q || (tick && cmp_a == '0)) begin
      cnt_n = '0;
      dn_n = 1'b0;
    end else if (tick && !mode) begin
      pe = cnt >= cmp_a - CNT_WIDTH'(1);
      cnt_n = pe ? '0 : cnt + CNT_WIDTH'(1);
    end else if (tick && !dn) begin
      cnt_n = cnt >= cmp_a ? cmp_a : cnt + CNT_WIDTH'(1);
      dn_n = cnt_n == cmp_a;
    end else if (tick) begin
      pe = cnt <= CNT_WIDTH'(1);
      cnt_n = pe ? '0 : cnt - CNT_WIDTH'(1);
      dn_n = ~pe;
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      {ovie, en, clr_q, mode, dn, ovif} <= '0;
      pscr <= '0;
      pscnt <= '0;
      cnt <= '0;
      cmp_s <= '0;
      cmp_a <= '0;
      pol <= '0;
      pwm_o <= '0;
    end else begin
      clr_q <= wr & off == 6'd0 & pwdata[2];
      if (wr & off == 6'd0) {mode, en, ovie} <= {pwdata[3], pwdata[1:0]};
      if (wr & off == 6'd1) pscr <= pwdata[PSCR_WIDTH-1:0];
      if (wr & off == 6'd3) cmp_s <= pwdata[CNT_WIDTH-1:0];
      if (wr & off == 6'd4) pol <= pwdata[CH_NUM-1:0];
      pscnt <= (~en | clr_q | tick | (wr & off == 6'd1)) ? '0 : pscnt + PSCR_WIDTH'(1);
      cnt <= cnt_n;
      dn <= dn_n;
      if (load) cmp_a <= cmp_s;
      ovif <= (pe & ovie) | (ovif & ~(wr & off == 6'd5 & pwdata[0]));
      pwm_o <= raw ^ pol;
    end
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    always_ff @(posedge pclk) begin
      if (!presetn) begin
        cr_s[c] <= '0;
        cr_a[c] <= '0;
      end else begin
        if (wr && off == 6'(16 + c)) cr_s[c] <= pwdata[CNT_WIDTH-1:0];
        if (load) cr_a[c] <= cr_s[c];
      end
    end
    assign raw[c] = en & (cmp_a != '0) & (cnt >= cr_a[c]);
  end

  always_comb begin
    cr_rd = '0;
    for (int i = 0; i < CH_NUM; i++) if (off == 6'(16 + i)) cr_rd = cr_s[i];
  end

  assign rd_val = off == 6'd0 ? {28'd0, mode, 1'b0, en, ovie}
    : off == 6'd1 ? 32'(pscr)
    : off == 6'd2 ? 32'(cnt)
    : off == 6'd3 ? 32'(cmp_s)
    : off == 6'd4 ? 32'(pol)
    : off == 6'd5 ? {31'd0, ovif}
    : 32'(cr_rd);
  assign prdata = rd ? rd_val : '0;
endmodule
